// File: rtl/door_supervisor_1596.sv
// Garage-door supervisor: input synchronizers, key debouncers, motor FSM with an
// enforced dead time between motor drives, run/auto-close timeouts and a latched fault.
module door_supervisor_1596 #(
  parameter int unsigned DEB_CYC    = 4,
  parameter int unsigned DEAD_CYC   = 8,
  parameter int unsigned RUN_MAX    = 1000,
  parameter int unsigned AUTO_CLOSE = 200
) (
  input  logic clk2m,
  input  logic rst_n,
  input  logic key_up,
  input  logic key_down,
  input  logic sense_up,
  input  logic sense_down,
  input  logic obstacle,
  output logic ml,
  output logic mr,
  output logic light_red,
  output logic light_green,
  output logic fault
);

  localparam int unsigned DBW    = $clog2(DEB_CYC + 1);
  localparam int unsigned TMAX_A = (DEAD_CYC > RUN_MAX) ? DEAD_CYC : RUN_MAX;
  localparam int unsigned TMAX   = (TMAX_A > AUTO_CLOSE) ? TMAX_A : AUTO_CLOSE;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_INIT, S_CLOSED, S_OPEN, S_DEAD, S_OPENING, S_CLOSING, S_FAULT
  } state_t;

  state_t         state, state_next;
  logic           tgt_open, tgt_open_next;
  logic [TW-1:0]  tmr, tmr_next;
  logic [7:0]     blink_cnt, blink_cnt_next;
  logic           ml_next, mr_next, red_next, green_next, fault_next;

  // Two-flop synchronizers, bit order {obstacle, sense_down, sense_up, key_down, key_up}
  logic [4:0] sync_a, sync_b;
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {obstacle, sense_down, sense_up, key_down, key_up};
      sync_b <= sync_a;
    end
  end

  logic su, sd, ob;
  assign su = sync_b[2];
  assign sd = sync_b[3];
  assign ob = sync_b[4];

  // Debouncers: one pulse per press once DEB_CYC high samples are seen; re-armed by a low sample
  logic [DBW-1:0] deb_cnt [2];
  logic [1:0]     deb_fired, press;
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      deb_fired <= '0;
      press     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!sync_b[i]) begin
          deb_cnt[i]   <= '0;
          deb_fired[i] <= 1'b0;
          press[i]     <= 1'b0;
        end else begin
          if (deb_cnt[i] != DBW'(DEB_CYC)) deb_cnt[i] <= deb_cnt[i] + DBW'(1);
          press[i] <= (deb_cnt[i] == DBW'(DEB_CYC)) && !deb_fired[i];
          if (deb_cnt[i] == DBW'(DEB_CYC)) deb_fired[i] <= 1'b1;
        end
      end
    end
  end

  logic up_p, dn_p;
  assign up_p = press[0] & ~press[1];
  assign dn_p = press[1] & ~press[0];

  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      tgt_open    <= 1'b0;
      tmr         <= '0;
      blink_cnt   <= '0;
      ml          <= 1'b0;
      mr          <= 1'b0;
      light_red   <= 1'b0;
      light_green <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      tgt_open    <= tgt_open_next;
      tmr         <= tmr_next;
      blink_cnt   <= blink_cnt_next;
      ml          <= ml_next;
      mr          <= mr_next;
      light_red   <= red_next;
      light_green <= green_next;
      fault       <= fault_next;
    end
  end

  // Next state; one shared timer serves dead time, run limit and auto-close
  always_comb begin
    state_next    = state;
    tgt_open_next = tgt_open;
    if (su && sd) begin
      state_next = S_FAULT;
    end else begin
      case (state)
        S_INIT: begin
          if (sd)        state_next = S_CLOSED;
          else if (su)   state_next = S_OPEN;
          else if (up_p) begin state_next = S_DEAD; tgt_open_next = 1'b1; end
          else if (dn_p) begin state_next = S_DEAD; tgt_open_next = 1'b0; end
        end
        S_CLOSED: begin
          if (up_p) begin state_next = S_DEAD; tgt_open_next = 1'b1; end
        end
        S_OPEN: begin
          if (dn_p || (!ob && tmr == TW'(AUTO_CLOSE - 1))) begin
            state_next    = S_DEAD;
            tgt_open_next = 1'b0;
          end
        end
        S_DEAD: begin
          if (tmr == TW'(DEAD_CYC - 1)) state_next = tgt_open ? S_OPENING : S_CLOSING;
        end
        S_OPENING: begin
          if (su)        state_next = S_OPEN;
          else if (dn_p) begin state_next = S_DEAD; tgt_open_next = 1'b0; end
          else if (tmr == TW'(RUN_MAX - 1)) state_next = S_FAULT;
        end
        S_CLOSING: begin
          if (ob || up_p) begin state_next = S_DEAD; tgt_open_next = 1'b1; end
          else if (sd)    state_next = S_CLOSED;
          else if (tmr == TW'(RUN_MAX - 1)) state_next = S_FAULT;
        end
        S_FAULT: state_next = S_FAULT;
        default: state_next = S_INIT;
      endcase
    end

    if (state_next != state)                tmr_next = '0;
    else if (state == S_OPEN && ob)         tmr_next = '0;
    else if (tmr != TW'(TMAX))              tmr_next = tmr + TW'(1);
    else                                    tmr_next = tmr;

    // Free-running modulo-256 divider for the fault blink
    blink_cnt_next = (state == S_FAULT) ? blink_cnt + 8'd1 : 8'd0;
  end

  // Output decode from the next state so the lamps/motors change with the state register
  always_comb begin
    ml_next    = (state_next == S_CLOSING);
    mr_next    = (state_next == S_OPENING);
    green_next = (state_next == S_OPEN);
    fault_next = (state_next == S_FAULT);
    red_next   = 1'b0;
    case (state_next)
      S_CLOSED, S_DEAD, S_OPENING, S_CLOSING: red_next = 1'b1;
      S_FAULT: begin
        if (state != S_FAULT)          red_next = 1'b1;
        else if (blink_cnt == 8'hFF)   red_next = ~light_red;
        else                           red_next = light_red;
      end
      default: red_next = 1'b0;
    endcase
  end

endmodule
